// File: rtl/jtag_uart_response_encoder_if.sv
// Signal bundle for the JTAG-UART response encoder. It carries the payload push, the
// token handshake and the Avalon-MM master port toward the JTAG-UART slave.
interface jtag_uart_response_encoder_if #(
   parameter int unsigned FIFO_DEPTH = 16
);
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    iDATA;
   logic          iDATA_VALID;
   logic          oDATA_READY;
   logic          iTOKEN_VALID;
   logic [7:0]    iTOKEN_CODE;
   logic          oTOKEN_ACCEPT;
   logic [LW-1:0] oFIFO_LEVEL;
   logic          oBUSY;
   logic          oJTAG_SLAVE_ADDR;
   logic          oJTAG_SLAVE_RDREQ;
   logic [31:0]   iJTAG_SLAVE_RDDATA;
   logic          oJTAG_SLAVE_WRREQ;
   logic [31:0]   oJTAG_SLAVE_WRDATA;
   logic          iJTAG_SLAVE_WAIT;

   // Encoder side
   modport slave (
      input  iDATA, iDATA_VALID, iTOKEN_VALID, iTOKEN_CODE,
      input  iJTAG_SLAVE_RDDATA, iJTAG_SLAVE_WAIT,
      output oDATA_READY, oTOKEN_ACCEPT, oFIFO_LEVEL, oBUSY,
      output oJTAG_SLAVE_ADDR, oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ, oJTAG_SLAVE_WRDATA
   );

   // Environment side: payload/token source plus the JTAG-UART slave
   modport master (
      output iDATA, iDATA_VALID, iTOKEN_VALID, iTOKEN_CODE,
      output iJTAG_SLAVE_RDDATA, iJTAG_SLAVE_WAIT,
      input  oDATA_READY, oTOKEN_ACCEPT, oFIFO_LEVEL, oBUSY,
      input  oJTAG_SLAVE_ADDR, oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ, oJTAG_SLAVE_WRDATA
   );
endinterface

// File: rtl/jtag_uart_response_encoder.sv
// Host-bound transmit path: payload FIFO plus escape/token framing. Every byte is written
// to the JTAG-UART data register only after a control-register poll shows enough space.
module jtag_uart_response_encoder #(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter logic [7:0]  ESC_BYTE    = 8'hFE,
   parameter logic [7:0]  ESC_LITERAL = 8'h00
) (
   input  logic                          iCLK,
   input  logic                          iRST_N,
   jtag_uart_response_encoder_if.slave   bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_POLL, S_POLL_GAP, S_WR0, S_WR1} state_t;

   state_t        r_state;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_count;
   logic [7:0]    r_byte0;
   logic [7:0]    r_byte1;
   logic          r_two;
   logic          r_addr;
   logic          r_rdreq;
   logic          r_wrreq;
   logic [7:0]    r_wrbyte;
   logic          r_tok_acc;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [7:0]    w_head;
   logic [15:0]   w_wspace;
   logic [15:0]   w_need;
   logic          w_unused;

   assign w_full   = (r_count == LW'(FIFO_DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_push   = bus.iDATA_VALID && !w_full;
   // Tokens win over payload, so a pending token blocks the pop.
   assign w_pop    = (r_state == S_IDLE) && !bus.iTOKEN_VALID && !w_empty;
   assign w_head   = r_mem[r_rd_ptr];
   assign w_wspace = bus.iJTAG_SLAVE_RDDATA[31:16];
   assign w_need   = r_two ? 16'd2 : 16'd1;
   assign w_unused = ^bus.iJTAG_SLAVE_RDDATA[15:0];

   always_ff @(posedge iCLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.iDATA;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LW'(1);
            2'b01:   r_count <= r_count - LW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state   <= S_IDLE;
         r_byte0   <= '0;
         r_byte1   <= '0;
         r_two     <= 1'b0;
         r_addr    <= 1'b0;
         r_rdreq   <= 1'b0;
         r_wrreq   <= 1'b0;
         r_wrbyte  <= '0;
         r_tok_acc <= 1'b0;
      end else begin
         r_tok_acc <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.iTOKEN_VALID) begin
                  r_byte0   <= ESC_BYTE;
                  r_byte1   <= bus.iTOKEN_CODE;
                  r_two     <= 1'b1;
                  r_tok_acc <= 1'b1;
                  r_addr    <= 1'b1;
                  r_rdreq   <= 1'b1;
                  r_state   <= S_POLL;
               end else if (!w_empty) begin
                  if (w_head == ESC_BYTE) begin
                     r_byte0 <= ESC_BYTE;
                     r_two   <= 1'b1;
                  end else begin
                     r_byte0 <= w_head;
                     r_two   <= 1'b0;
                  end
                  r_byte1 <= ESC_LITERAL;
                  r_addr  <= 1'b1;
                  r_rdreq <= 1'b1;
                  r_state <= S_POLL;
               end
            end
            S_POLL: begin
               if (!bus.iJTAG_SLAVE_WAIT) begin
                  r_rdreq <= 1'b0;
                  r_addr  <= 1'b0;
                  // The whole pair must fit, so a pair is never split across polls.
                  if (w_wspace >= w_need) begin
                     r_wrreq  <= 1'b1;
                     r_wrbyte <= r_byte0;
                     r_state  <= S_WR0;
                  end else begin
                     r_state <= S_POLL_GAP;
                  end
               end
            end
            S_POLL_GAP: begin
               r_addr  <= 1'b1;
               r_rdreq <= 1'b1;
               r_state <= S_POLL;
            end
            S_WR0: begin
               if (!bus.iJTAG_SLAVE_WAIT) begin
                  if (r_two) begin
                     r_wrbyte <= r_byte1;
                     r_state  <= S_WR1;
                  end else begin
                     r_wrreq <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            S_WR1: begin
               if (!bus.iJTAG_SLAVE_WAIT) begin
                  r_wrreq <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_addr  <= 1'b0;
               r_rdreq <= 1'b0;
               r_wrreq <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.oDATA_READY        = !w_full;
   assign bus.oFIFO_LEVEL        = r_count;
   assign bus.oTOKEN_ACCEPT      = r_tok_acc;
   assign bus.oBUSY              = (r_state != S_IDLE);
   assign bus.oJTAG_SLAVE_ADDR   = r_addr;
   assign bus.oJTAG_SLAVE_RDREQ  = r_rdreq;
   assign bus.oJTAG_SLAVE_WRREQ  = r_wrreq;
   assign bus.oJTAG_SLAVE_WRDATA = {24'd0, r_wrbyte};

endmodule
